hack_cpu_mc: RTL and testbench
==============================

# hack_cpu_mc

Multi-cycle, parametrised successor to the single-cycle Hack CPU. It executes the Hack instruction set over a configurable data width and address width. Instruction fetch uses a valid handshake, and data memory uses a req/ack handshake with arbitrary wait states, so the core can sit on slow or shared ROM/RAM instead of ideal single-cycle memories. It sits between the instruction ROM port and the data-memory bus in the computer top level.

## Interface
- WIDTH, 16, data/instruction width; must be >= 16
- AW, 15, address width of pc and addressM; must be <= WIDTH-1
- RESET_PC, 0, pc value after reset
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- inst  in  WIDTH  instruction word at address pc
- inst_valid  in  1  inst is valid this cycle
- inM  in  WIDTH  read data from data memory
- mem_ack  in  1  data-memory transaction complete this cycle
- outM  out  WIDTH  write data (registered)
- addressM  out  AW  data-memory address
- writeM  out  1  write request, held until mem_ack
- readM  out  1  read request, held until mem_ack
- pc  out  AW  address of instruction being fetched or executed
- retire  out  1  one-cycle pulse on the edge an instruction completes

## Operation
- Registers: A (WIDTH), D (WIDTH), PC (AW), IR (WIDTH), MDR (WIDTH), addr_r (AW), outM_r (WIDTH), state.
- Decode from IR:
  - op = IR[WIDTH-1]; A-instruction when op=0.
  - C fields are fixed at the low bits: a=IR[12], zx,nx,zy,ny,f,no=IR[11:6], d1,d2,d3=IR[5:3], j1,j2,j3=IR[2:0].
  - C-instruction bits IR[WIDTH-2:13] are ignored.
- ALU:
  - Standard Hack ALU at WIDTH bits, operands x=D and y=(a ? MDR : A).
  - Arithmetic is modulo 2^WIDTH.
  - ng = out[WIDTH-1]; zr = (out==0).
- Jump condition: jmp = op & ((j1&ng) | (j2&zr) | (j3&~ng&~zr)).
- States:
  - FETCH:
    - Wait for inst_valid.
    - On an edge with inst_valid=1: IR<=inst.
    - Next state is MREAD if inst is a C-instruction with a=1, else EXEC.
  - MREAD:
    - readM=1, addressM=A[AW-1:0].
    - On mem_ack: MDR<=inM, go to EXEC.
  - EXEC (exactly one cycle):
    - A-instruction: A<=IR.
    - C-instruction: if d2, D<=alu. If d1, A<=alu. If d3, outM_r<=alu and addr_r<=old A[AW-1:0].
    - PC <= jmp ? old A[AW-1:0] : PC+1. The increment wraps modulo 2^AW.
    - The jump target and write address always use A before this instruction's update.
    - If d3: go to MWRITE. Otherwise: retire=1, go to FETCH.
  - MWRITE:
    - writeM=1, addressM=addr_r, outM=outM_r.
    - On mem_ack: retire=1, go to FETCH.
- addressM = addr_r in MWRITE, else A[AW-1:0].
- outM always equals outM_r.
- readM and writeM are never asserted together.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - state=FETCH, PC=RESET_PC.
  - A, D, IR, MDR, outM_r, addr_r = 0.
  - readM=0, writeM=0, retire=0.
- Reset mid-operation:
  - Any pending read or write is abandoned; readM/writeM drop immediately and no register commits.
  - The first fetch after reset_n rises is at RESET_PC.
- Handshakes:
  - mem_ack may be high in the same cycle readM/writeM first rise (zero-wait); the transaction then completes on that edge.
  - mem_ack is ignored outside MREAD/MWRITE.
  - inst_valid is ignored outside FETCH.
  - inst must remain stable only on the capturing edge.
- Minimum cycles per instruction at zero wait:
  - A-instruction: 2.
  - C-instruction without M: 2.
  - C-instruction reading M: 3.
  - C-instruction writing M: 3.
  - C-instruction reading and writing M: 4.
  - Each wait cycle on inst_valid or mem_ack adds one.
- pc is stable from FETCH entry until the EXEC edge.
- retire is a one-cycle pulse on the final cycle of each instruction.

## Test plan
- Reset, arithmetic and retire (WIDTH=16):
  - Stimulus: hold reset_n=0 with inst_valid=1, release, run "@5; D=A; @7; D=D+A".
  - Required: pc=0 during reset; after 4 instructions D=12, A=7, pc=4, readM and writeM never asserted, 4 retire pulses, each on its instruction's final cycle.
- Read-modify-write with waits:
  - Stimulus: A=100, memory[100]=0x00FF, execute "M=M+1"; ack each transaction after 2 wait cycles.
  - Required: readM held 3 cycles at addressM=100; then writeM held 3 cycles with outM=0x0100 at addressM=100; retire only at the write ack.
- Jump semantics:
  - Stimulus: D=-1, A=40, execute "A=D;JLT".
  - Required: pc=40 next (old A), A=0xFFFF.
  - Stimulus: D=0, execute "D;JGT".
  - Required: pc increments.
- Wrap and width (WIDTH=24, AW=4):
  - Stimulus: run from pc=15 with a non-jump instruction.
  - Required: pc wraps to 0.
  - Stimulus: D=0x7FFFFF, execute "D=D+1".
  - Required: D=0x800000 and ng observed set by a following "D;JLT" jump.
- Reset during MWRITE:
  - Stimulus: drop reset_n while writeM=1 and mem_ack=0.
  - Required: writeM falls without a clock edge, and the first fetch after release is at RESET_PC with A=D=0.
- Fetch stall:
  - Stimulus: inst_valid low for 5 cycles.
  - Required: pc constant and no register change until the valid edge.

Source files
------------

// File: rtl/hack_cpu_mc_if.sv
// Fetch and data-memory port bundle of the multi-cycle Hack core.
// Master is the core. The slave side supplies instructions and data and returns mem_ack.
interface hack_cpu_mc_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 15
);
   logic [WIDTH-1:0] inst;
   logic             inst_valid;
   logic [WIDTH-1:0] inM;
   logic             mem_ack;
   logic [WIDTH-1:0] outM;
   logic [AW-1:0]    addressM;
   logic             writeM;
   logic             readM;
   logic [AW-1:0]    pc;
   logic             retire;

   modport master (
      input  inst, inst_valid, inM, mem_ack,
      output outM, addressM, writeM, readM, pc, retire
   );

   modport slave (
      output inst, inst_valid, inM, mem_ack,
      input  outM, addressM, writeM, readM, pc, retire
   );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH -> [MREAD] -> EXEC -> [MWRITE]; 2 to 4 cycles per instruction.
// Backpressure: stalls in FETCH until inst_valid, and holds readM/writeM until mem_ack.
module hack_cpu_mc #(
   parameter int WIDTH    = 16,
   parameter int AW       = 15,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   hack_cpu_mc_if.master bus
);
   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      MREAD  = 2'd1,
      EXEC   = 2'd2,
      MWRITE = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] mdr;
   logic [WIDTH-1:0] out_reg;
   logic [AW-1:0]    pc_reg;
   logic [AW-1:0]    addr_reg;

   logic op, a_bit, zx, nx, zy, ny, f, no;
   logic d1, d2, d3, j1, j2, j3;
   logic unused_ir;

   assign op    = ir[WIDTH-1];
   assign a_bit = ir[12];
   assign zx    = ir[11];
   assign nx    = ir[10];
   assign zy    = ir[9];
   assign ny    = ir[8];
   assign f     = ir[7];
   assign no    = ir[6];
   assign d1    = ir[5];
   assign d2    = ir[4];
   assign d3    = ir[3];
   assign j1    = ir[2];
   assign j2    = ir[1];
   assign j3    = ir[0];
   // Opcode filler bits between op and the a bit carry no meaning.
   assign unused_ir = ^ir[WIDTH-2:13];

   logic [WIDTH-1:0] x_z, x_n, y_sel, y_z, y_n, alu_raw, alu;
   logic             ng, zr, jmp;
   logic             c_write, fetch_read;
   logic             read_req, write_req, done;

   always_comb begin
      x_z     = zx ? '0 : d_reg;
      x_n     = nx ? ~x_z : x_z;
      y_sel   = a_bit ? mdr : a_reg;
      y_z     = zy ? '0 : y_sel;
      y_n     = ny ? ~y_z : y_z;
      alu_raw = f ? (x_n + y_n) : (x_n & y_n);
      alu     = no ? ~alu_raw : alu_raw;
   end

   assign ng         = alu[WIDTH-1];
   assign zr         = (alu == '0);
   assign jmp        = op & ((j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr));
   assign c_write    = op & d3;
   // The M-read decision is taken from the incoming word so MREAD follows FETCH directly.
   assign fetch_read = bus.inst[WIDTH-1] & bus.inst[12];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      read_req  = 1'b0;
      write_req = 1'b0;
      done      = 1'b0;
      case (state)
         FETCH: begin
            if (bus.inst_valid) begin
               state_nxt = fetch_read ? MREAD : EXEC;
            end
         end
         MREAD: begin
            read_req = 1'b1;
            if (bus.mem_ack) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            if (c_write) begin
               state_nxt = MWRITE;
            end else begin
               done      = 1'b1;
               state_nxt = FETCH;
            end
         end
         MWRITE: begin
            write_req = 1'b1;
            if (bus.mem_ack) begin
               done      = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_reg    <= '0;
         d_reg    <= '0;
         ir       <= '0;
         mdr      <= '0;
         out_reg  <= '0;
         addr_reg <= '0;
         pc_reg   <= AW'(RESET_PC);
      end else begin
         case (state)
            FETCH: begin
               if (bus.inst_valid) begin
                  ir <= bus.inst;
               end
            end
            MREAD: begin
               if (bus.mem_ack) begin
                  mdr <= bus.inM;
               end
            end
            EXEC: begin
               // Jump target and write address both see A from before this instruction.
               if (!op) begin
                  a_reg <= ir;
               end else begin
                  if (d2) d_reg <= alu;
                  if (d1) a_reg <= alu;
                  if (d3) begin
                     out_reg  <= alu;
                     addr_reg <= a_reg[AW-1:0];
                  end
               end
               pc_reg <= jmp ? a_reg[AW-1:0] : pc_reg + AW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.readM    = read_req;
   assign bus.writeM   = write_req;
   assign bus.retire   = done;
   assign bus.outM     = out_reg;
   assign bus.pc       = pc_reg;
   assign bus.addressM = (state == MWRITE) ? addr_reg : a_reg[AW-1:0];
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: a 16-bit core and a 24-bit/AW=4 core share one driver.
module tb_hack_cpu_mc;
   logic clk;
   logic rst16_n, rst24_n;
   logic sel24;
   logic [23:0] t_inst, t_inM;
   logic t_valid, t_ack;

   hack_cpu_mc_if #(.WIDTH(16), .AW(15)) b16 ();
   hack_cpu_mc_if #(.WIDTH(24), .AW(4))  b24 ();

   hack_cpu_mc #(.WIDTH(16), .AW(15), .RESET_PC(0))  dut16 (.clk(clk), .reset_n(rst16_n), .bus(b16.master));
   hack_cpu_mc #(.WIDTH(24), .AW(4),  .RESET_PC(15)) dut24 (.clk(clk), .reset_n(rst24_n), .bus(b24.master));

   assign b16.inst       = t_inst[15:0];
   assign b16.inM        = t_inM[15:0];
   assign b16.inst_valid = t_valid & ~sel24;
   assign b16.mem_ack    = t_ack & ~sel24;
   assign b24.inst       = t_inst;
   assign b24.inM        = t_inM;
   assign b24.inst_valid = t_valid & sel24;
   assign b24.mem_ack    = t_ack & sel24;

   logic [14:0] o_pc, o_addr;
   logic [23:0] o_out;
   logic        o_readM, o_writeM, o_retire;
   assign o_pc     = sel24 ? {11'd0, b24.pc} : b16.pc;
   assign o_addr   = sel24 ? {11'd0, b24.addressM} : b16.addressM;
   assign o_out    = sel24 ? b24.outM : {8'd0, b16.outM};
   assign o_readM  = sel24 ? b24.readM : b16.readM;
   assign o_writeM = sel24 ? b24.writeM : b16.writeM;
   assign o_retire = sel24 ? b24.retire : b16.retire;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int n_cyc, rd_cyc, wr_cyc, n_ret;
   logic [23:0] wr_dat;
   logic [14:0] rd_addr, wr_addr, pc_after, addr_after;
   bit pc_moved, a_moved, both_any;

   function automatic logic [23:0] c16(input logic a, input logic [5:0] c, input logic [2:0] d, input logic [2:0] j);
      return {8'h00, 3'b111, a, c, d, j};
   endfunction

   function automatic logic [23:0] c24(input logic a, input logic [5:0] c, input logic [2:0] d, input logic [2:0] j);
      return {1'b1, 10'b1010011100, a, c, d, j};
   endfunction

   // Runs one instruction to its retire pulse and records what the buses did.
   task automatic run(input logic [23:0] ins, input int vwait, input int mwait, input logic [23:0] rdata, input logic idle_ack);
      int wc;
      bit done;
      logic [14:0] pc0, a0;
      n_cyc = 0; rd_cyc = 0; wr_cyc = 0; n_ret = 0;
      wr_dat = '0; rd_addr = '0; wr_addr = '0;
      pc_moved = 0; a_moved = 0; wc = 0; done = 0; pc0 = '0; a0 = '0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (c == 0) begin
            pc0 = o_pc;
            a0  = o_addr;
         end
         t_valid = (c >= vwait);
         t_inst  = (c >= vwait) ? ins : 24'h5A5A5A;
         t_inM   = rdata;
         if (o_readM || o_writeM) begin
            t_ack = (wc == mwait);
            wc = (wc == mwait) ? 0 : wc + 1;
         end else begin
            t_ack = idle_ack;
         end
         #1;
         n_cyc++;
         if (o_readM) begin rd_cyc++; rd_addr = o_addr; end
         if (o_writeM) begin wr_cyc++; wr_addr = o_addr; wr_dat = o_out; end
         if (o_readM && o_writeM) both_any = 1;
         if (o_pc != pc0) pc_moved = 1;
         if (c < vwait && o_addr != a0) a_moved = 1;
         if (o_retire) begin n_ret++; done = 1; end
      end
      @(posedge clk);
      #1;
      t_valid = 0;
      t_ack = 0;
      pc_after = o_pc;
      addr_after = o_addr;
   endtask

   task automatic test_reset();
      sel24 = 0; t_valid = 1; t_ack = 1;
      t_inst = c16(0, 6'b001100, 3'b001, 3'b000);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (o_pc !== 15'd0) begin failures++; $display("FAIL reset_pc got %0h want 0", o_pc); end
      checks++; if (o_readM !== 1'b0 || o_writeM !== 1'b0) begin failures++; $display("FAIL reset_rw got r=%b w=%b want 0 0", o_readM, o_writeM); end
      checks++; if (o_retire !== 1'b0) begin failures++; $display("FAIL reset_retire got %b want 0", o_retire); end
      checks++; if (o_out !== 24'd0) begin failures++; $display("FAIL reset_outM got %0h want 0", o_out); end
      t_valid = 0; t_ack = 0;
      rst16_n = 1;
   endtask

   task automatic test_arith();
      logic [23:0] prog [4];
      int tot_ret, tot_rw;
      prog[0] = 24'd5;
      prog[1] = c16(0, 6'b110000, 3'b010, 3'b000);
      prog[2] = 24'd7;
      prog[3] = c16(0, 6'b000010, 3'b010, 3'b000);
      tot_ret = 0; tot_rw = 0;
      for (int i = 0; i < 4; i++) begin
         run(prog[i], 0, 0, 24'd0, 1'b0);
         tot_ret += n_ret;
         tot_rw += rd_cyc + wr_cyc;
         checks++; if (n_cyc !== 2) begin failures++; $display("FAIL arith_cycles[%0d] got %0d want 2", i, n_cyc); end
      end
      checks++; if (tot_ret !== 4) begin failures++; $display("FAIL arith_retires got %0d want 4", tot_ret); end
      checks++; if (tot_rw !== 0) begin failures++; $display("FAIL arith_mem_cycles got %0d want 0", tot_rw); end
      checks++; if (pc_after !== 15'd4) begin failures++; $display("FAIL arith_pc got %0h want 4", pc_after); end
      checks++; if (addr_after !== 15'd7) begin failures++; $display("FAIL arith_A got %0h want 7", addr_after); end
      run(c16(0, 6'b001100, 3'b001, 3'b000), 0, 0, 24'd0, 1'b0);
      checks++; if (wr_dat !== 24'd12) begin failures++; $display("FAIL arith_D got %0h want c", wr_dat); end
      checks++; if (wr_addr !== 15'd7 || n_cyc !== 3) begin failures++; $display("FAIL arith_store got addr=%0h cyc=%0d want 7 3", wr_addr, n_cyc); end
   endtask

   task automatic test_rmw();
      run(24'd100, 0, 0, 24'd0, 1'b0);
      run(c16(1, 6'b110111, 3'b001, 3'b000), 0, 2, 24'h00FF, 1'b0);
      checks++; if (rd_cyc !== 3 || rd_addr !== 15'd100) begin failures++; $display("FAIL rmw_read got cyc=%0d addr=%0d want 3 100", rd_cyc, rd_addr); end
      checks++; if (wr_cyc !== 3 || wr_addr !== 15'd100) begin failures++; $display("FAIL rmw_write got cyc=%0d addr=%0d want 3 100", wr_cyc, wr_addr); end
      checks++; if (wr_dat !== 24'h000100) begin failures++; $display("FAIL rmw_data got %0h want 100", wr_dat); end
      checks++; if (n_cyc !== 8 || n_ret !== 1) begin failures++; $display("FAIL rmw_retire got cyc=%0d ret=%0d want 8 1", n_cyc, n_ret); end
      run(c16(1, 6'b110111, 3'b001, 3'b000), 0, 0, 24'h1234, 1'b0);
      checks++; if (n_cyc !== 4 || wr_dat !== 24'h1235) begin failures++; $display("FAIL rmw_zero_wait got cyc=%0d dat=%0h want 4 1235", n_cyc, wr_dat); end
      run(c16(1, 6'b110000, 3'b010, 3'b000), 0, 0, 24'hBEEF, 1'b0);
      checks++; if (n_cyc !== 3) begin failures++; $display("FAIL dm_cycles got %0d want 3", n_cyc); end
      run(c16(0, 6'b001100, 3'b001, 3'b000), 0, 0, 24'd0, 1'b0);
      checks++; if (wr_dat !== 24'h00BEEF || pc_after !== 15'd10) begin failures++; $display("FAIL dm_value got dat=%0h pc=%0h want beef a", wr_dat, pc_after); end
   endtask

   task automatic test_jump();
      run(c16(0, 6'b111010, 3'b010, 3'b000), 0, 0, 24'd0, 1'b0);
      run(24'd40, 0, 0, 24'd0, 1'b0);
      run(c16(0, 6'b001100, 3'b100, 3'b100), 0, 0, 24'd0, 1'b0);
      checks++; if (pc_after !== 15'd40) begin failures++; $display("FAIL jlt_taken got pc=%0h want 28", pc_after); end
      run(c16(0, 6'b110000, 3'b001, 3'b000), 0, 0, 24'd0, 1'b0);
      checks++; if (wr_dat !== 24'h00FFFF || wr_addr !== 15'h7FFF) begin failures++; $display("FAIL jlt_A got dat=%0h addr=%0h want ffff 7fff", wr_dat, wr_addr); end
      run(c16(0, 6'b101010, 3'b010, 3'b000), 0, 0, 24'd0, 1'b0);
      run(c16(0, 6'b001100, 3'b000, 3'b001), 0, 0, 24'd0, 1'b0);
      checks++; if (pc_after !== 15'd43) begin failures++; $display("FAIL jgt_not_taken got pc=%0h want 2b", pc_after); end
      run(c16(0, 6'b001100, 3'b000, 3'b010), 0, 0, 24'd0, 1'b0);
      checks++; if (pc_after !== 15'h7FFF) begin failures++; $display("FAIL jeq_taken got pc=%0h want 7fff", pc_after); end
      run(c16(0, 6'b011111, 3'b010, 3'b000), 0, 0, 24'd0, 1'b0);
      checks++; if (pc_after !== 15'd0) begin failures++; $display("FAIL pc_wrap16 got pc=%0h want 0", pc_after); end
   endtask

   task automatic test_stall();
      run(24'd3, 5, 0, 24'd0, 1'b1);
      checks++; if (n_cyc !== 7) begin failures++; $display("FAIL stall_cycles got %0d want 7", n_cyc); end
      checks++; if (pc_moved !== 1'b0 || a_moved !== 1'b0) begin failures++; $display("FAIL stall_hold got pc_moved=%b a_moved=%b want 0 0", pc_moved, a_moved); end
      checks++; if (pc_after !== 15'd1 || addr_after !== 15'd3) begin failures++; $display("FAIL stall_result got pc=%0h A=%0h want 1 3", pc_after, addr_after); end
      run(c16(0, 6'b001100, 3'b001, 3'b000), 0, 1, 24'd0, 1'b1);
      checks++; if (n_cyc !== 4 || wr_dat !== 24'd1 || wr_addr !== 15'd3) begin failures++; $display("FAIL idle_ack_write got cyc=%0d dat=%0h addr=%0h want 4 1 3", n_cyc, wr_dat, wr_addr); end
   endtask

   task automatic test_reset_mwrite();
      bit got;
      @(negedge clk);
      t_inst = c16(0, 6'b001100, 3'b001, 3'b000);
      t_valid = 1; t_ack = 0; got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         #1;
         got = o_writeM;
      end
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL rst_mw_reach got writeM=%b want 1", got); end
      #1;
      rst16_n = 0;
      #1;
      checks++; if (o_writeM !== 1'b0 || o_readM !== 1'b0) begin failures++; $display("FAIL rst_mw_drop got r=%b w=%b want 0 0", o_readM, o_writeM); end
      checks++; if (o_pc !== 15'd0 || o_retire !== 1'b0) begin failures++; $display("FAIL rst_mw_pc got pc=%0h ret=%b want 0 0", o_pc, o_retire); end
      t_valid = 0;
      @(negedge clk);
      rst16_n = 1;
      #1;
      checks++; if (o_pc !== 15'd0 || o_addr !== 15'd0) begin failures++; $display("FAIL rst_mw_after got pc=%0h A=%0h want 0 0", o_pc, o_addr); end
      run(c16(0, 6'b001100, 3'b001, 3'b000), 0, 0, 24'd0, 1'b0);
      checks++; if (wr_dat !== 24'd0 || wr_addr !== 15'd0 || pc_after !== 15'd1) begin failures++; $display("FAIL rst_mw_D got dat=%0h addr=%0h pc=%0h want 0 0 1", wr_dat, wr_addr, pc_after); end
   endtask

   task automatic test_wide();
      sel24 = 1; t_valid = 1;
      t_inst = c24(0, 6'b011111, 3'b010, 3'b000);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (o_pc !== 15'd15) begin failures++; $display("FAIL w24_reset_pc got %0h want f", o_pc); end
      t_valid = 0;
      rst24_n = 1;
      run(c24(0, 6'b011111, 3'b010, 3'b000), 0, 0, 24'd0, 1'b0);
      checks++; if (pc_after !== 15'd0 || n_cyc !== 2) begin failures++; $display("FAIL w24_pc_wrap got pc=%0h cyc=%0d want 0 2", pc_after, n_cyc); end
      run(24'h7FFFFF, 0, 0, 24'd0, 1'b0);
      checks++; if (addr_after !== 15'hF) begin failures++; $display("FAIL w24_A got %0h want f", addr_after); end
      run(c24(0, 6'b110000, 3'b010, 3'b000), 0, 0, 24'd0, 1'b0);
      run(c24(0, 6'b011111, 3'b010, 3'b000), 0, 0, 24'd0, 1'b0);
      run(c24(0, 6'b001100, 3'b001, 3'b000), 0, 0, 24'd0, 1'b0);
      checks++; if (wr_dat !== 24'h800000 || wr_addr !== 15'hF) begin failures++; $display("FAIL w24_D got dat=%0h addr=%0h want 800000 f", wr_dat, wr_addr); end
      run(24'd9, 0, 0, 24'd0, 1'b0);
      run(c24(0, 6'b001100, 3'b000, 3'b100), 0, 0, 24'd0, 1'b0);
      checks++; if (pc_after !== 15'd9) begin failures++; $display("FAIL w24_ng_jlt got pc=%0h want 9", pc_after); end
   endtask

   task automatic test_exclusive();
      checks++; if (both_any !== 1'b0) begin failures++; $display("FAIL rw_exclusive got both=%b want 0", both_any); end
   endtask

   initial begin
      rst16_n = 0; rst24_n = 0; sel24 = 0;
      t_inst = '0; t_inM = '0; t_valid = 0; t_ack = 0; both_any = 0;
      test_reset();
      test_arith();
      test_rmw();
      test_jump();
      test_stall();
      test_reset_mwrite();
      test_wide();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
endmodule
